// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, state encoding and helpers for the regfile writeback arbiter slice.
// Imported by the interface, the scoreboard and the top level.
package regfile_wb_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 32;

  // Legacy-compatible state encodings; the enum below is built on them.
  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_FORCE  = 1'b1;

  typedef enum logic [0:0] {
    NORMAL = ST_NORMAL,
    FORCE  = ST_FORCE
  } arb_state_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_WIDTH-1:0] idx);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback, external-unit, issue, hazard-query and regfile-write signals.
// The arbiter takes the slave side; the surrounding pipeline (or a bench) takes master.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                      pipe_wb_valid;
  logic [REG_ADDR_WIDTH-1:0] pipe_wb_rd;
  logic [XLEN-1:0]           pipe_wb_data;
  logic                      pipe_wb_ready;

  logic                      ext_valid;
  logic [REG_ADDR_WIDTH-1:0] ext_rd;
  logic [XLEN-1:0]           ext_data;
  logic                      ext_ready;

  logic                      issue_valid;
  logic [REG_ADDR_WIDTH-1:0] issue_rd;
  logic                      issue_ready;

  logic [REG_ADDR_WIDTH-1:0] q_rs1;
  logic [REG_ADDR_WIDTH-1:0] q_rs2;
  logic [REG_ADDR_WIDTH-1:0] q_rd;
  logic                      rs1_busy;
  logic                      rs2_busy;
  logic                      rd_busy;

  logic [REG_ADDR_WIDTH-1:0] rf_rd;
  logic [XLEN-1:0]           rf_wdata;
  logic                      rf_wr_en;

  modport slave (
    input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    output pipe_wb_ready,
    input  ext_valid, ext_rd, ext_data,
    output ext_ready,
    input  issue_valid, issue_rd,
    output issue_ready,
    input  q_rs1, q_rs2, q_rd,
    output rs1_busy, rs2_busy, rd_busy,
    output rf_rd, rf_wdata, rf_wr_en
  );

  modport master (
    output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    input  pipe_wb_ready,
    output ext_valid, ext_rd, ext_data,
    input  ext_ready,
    output issue_valid, issue_rd,
    input  issue_ready,
    output q_rs1, q_rs2, q_rd,
    input  rs1_busy, rs2_busy, rd_busy,
    input  rf_rd, rf_wdata, rf_wr_en
  );

endinterface

// File: rtl/regfile_wb_arbiter_reg_scoreboard.sv
// Per-register busy bits for results outstanding in the long-latency unit.
// Queries are masked in the commit cycle because the regfile forwards the committing value.
module reg_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  output logic                      issue_ready,
  input  logic                      clr_valid,
  input  logic [REG_ADDR_WIDTH-1:0] clr_rd,
  input  logic [REG_ADDR_WIDTH-1:0] q_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] q_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] q_rd,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      rd_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_eff;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_next;

  // While reset is held the outputs already behave as if the scoreboard were empty.
  assign busy_eff    = reset ? '0 : busy;
  assign issue_ready = (issue_rd == '0) || !busy_eff[issue_rd];

  assign set_vec   = (issue_valid && issue_ready) ? reg_onehot(issue_rd) : '0;
  assign clr_vec   = clr_valid ? reg_onehot(clr_rd) : '0;
  // Set is applied after clear so a same-cycle set wins; bit 0 is forced low.
  assign busy_next = ((busy & ~clr_vec) | set_vec) & ~reg_onehot('0);

  function automatic logic query(input logic [REG_ADDR_WIDTH-1:0] q);
    return busy_eff[q] && !(clr_valid && (clr_rd == q));
  endfunction

  assign rs1_busy = query(q_rs1);
  assign rs2_busy = query(q_rs2);
  assign rd_busy  = query(q_rd);

  // NOTE: this vector is reset, unlike a data RAM -- a stale busy bit would stall decode forever.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between pipeline writeback and the long-latency
// unit, forcing the unit through after STARVE_LIMIT blocked cycles.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_t       state;
  arb_state_t       state_eff;
  arb_state_t       state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_next;

  logic                      pipe_ready;
  logic                      ext_ready;
  logic                      ext_accept;
  logic                      pipe_grant;
  logic [REG_ADDR_WIDTH-1:0] rf_rd;
  logic [XLEN-1:0]           rf_wdata;
  logic                      rf_wr_en;

  assign state_eff  = reset ? NORMAL : state;
  assign pipe_ready = (state_eff == NORMAL);
  assign ext_ready  = (state_eff == FORCE) || !bus.pipe_wb_valid;
  assign ext_accept = bus.ext_valid && ext_ready;
  assign pipe_grant = bus.pipe_wb_valid && pipe_ready;

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    rf_rd    = bus.ext_rd;
    rf_wdata = bus.ext_data;
    rf_wr_en = ext_accept && (bus.ext_rd != '0);
    if (pipe_grant) begin
      rf_rd    = bus.pipe_wb_rd;
      rf_wdata = bus.pipe_wb_data;
      rf_wr_en = (bus.pipe_wb_rd != '0);
    end
  end

  // Any cycle that is not a blocked ext request in NORMAL restarts the count.
  always_comb begin
    state_next      = NORMAL;
    starve_cnt_next = '0;
    if (state_eff == NORMAL && bus.ext_valid && !ext_ready) begin
      if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) state_next = FORCE;
      else starve_cnt_next = starve_cnt + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  assign bus.pipe_wb_ready = pipe_ready;
  assign bus.ext_ready     = ext_ready;
  assign bus.rf_rd         = rf_rd;
  assign bus.rf_wdata      = rf_wdata;
  assign bus.rf_wr_en      = rf_wr_en;

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .issue_ready (bus.issue_ready),
    .clr_valid   (ext_accept),
    .clr_rd      (bus.ext_rd),
    .q_rs1       (bus.q_rs1),
    .q_rs2       (bus.q_rs2),
    .q_rd        (bus.q_rd),
    .rs1_busy    (bus.rs1_busy),
    .rs2_busy    (bus.rs2_busy),
    .rd_busy     (bus.rd_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: write mux, starvation forcing, scoreboard and reset.
// Inputs change 1 ns after each rising edge; outputs are sampled mid-cycle.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_wb_valid = 1'b0; bus.pipe_wb_rd = '0; bus.pipe_wb_data = '0;
    bus.ext_valid     = 1'b0; bus.ext_rd     = '0; bus.ext_data     = '0;
    bus.issue_valid   = 1'b0; bus.issue_rd   = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.q_rs1 = '0; bus.q_rs2 = '0; bus.q_rd = '0;
    reset = 1'b1;
    #1;
    check("rst_pipe_ready", bus.pipe_wb_ready, 1'b1);
    check("rst_ext_ready",  bus.ext_ready,     1'b1);
    check("rst_wr_en",      bus.rf_wr_en,      1'b0);
    check("rst_issue_ready", bus.issue_ready,  1'b1);
    tick(); tick();
    reset = 1'b0;

    // Pipeline-only write.
    bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd5; bus.pipe_wb_data = 32'hDEADBEEF;
    #1;
    check("pipe_wr_en",    bus.rf_wr_en,      1'b1);
    check("pipe_rf_rd",    bus.rf_rd,         32'd5);
    check("pipe_rf_wdata", bus.rf_wdata,      32'hDEADBEEF);
    check("pipe_ready",    bus.pipe_wb_ready, 1'b1);
    check("pipe_ext_rdy",  bus.ext_ready,     1'b0);
    tick(); idle();

    // Issue x7, then re-issue is blocked.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    #1;
    check("iss7_ready", bus.issue_ready, 1'b1);
    tick();
    bus.q_rd = 5'd7;
    #1;
    check("iss7_rd_busy",  bus.rd_busy,     1'b1);
    check("iss7_again_rdy", bus.issue_ready, 1'b0);
    idle();

    // Ext commit of x7 with pipe idle; busy masked in the commit cycle.
    bus.ext_valid = 1'b1; bus.ext_rd = 5'd7; bus.ext_data = 32'h12345678; bus.q_rs1 = 5'd7;
    #1;
    check("ext7_ready",  bus.ext_ready, 1'b1);
    check("ext7_wr_en",  bus.rf_wr_en,  1'b1);
    check("ext7_rf_rd",  bus.rf_rd,     32'd7);
    check("ext7_wdata",  bus.rf_wdata,  32'h12345678);
    check("ext7_masked", bus.rs1_busy,  1'b0);
    tick(); idle();
    #1;
    check("ext7_cleared", bus.rs1_busy, 1'b0);

    // x9: second issue blocked until commit; then same-cycle issue+commit leaves it busy.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    #1;
    check("iss9_blocked", bus.issue_ready, 1'b0);
    tick();
    check("iss9_still_blk", bus.issue_ready, 1'b0);
    bus.ext_valid = 1'b1; bus.ext_rd = 5'd9; bus.ext_data = 32'h99;
    #1;
    check("iss9_commit_blk", bus.issue_ready, 1'b0);
    tick();
    bus.ext_valid = 1'b0;
    #1;
    check("iss9_freed", bus.issue_ready, 1'b1);
    bus.ext_valid = 1'b1;
    #1;
    check("iss9_same_rdy", bus.issue_ready, 1'b1);
    tick(); idle();
    bus.q_rd = 5'd9;
    #1;
    check("iss9_set_wins", bus.rd_busy, 1'b1);

    // Starvation: pipe every cycle, ext blocked four cycles, forced on the fifth.
    bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd1; bus.pipe_wb_data = 32'hAAAA0001;
    bus.ext_valid     = 1'b1; bus.ext_rd     = 5'd2; bus.ext_data     = 32'hBBBB0002;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("starve%0d_ext_rdy", c), bus.ext_ready,     1'b0);
      check($sformatf("starve%0d_pipe",    c), bus.pipe_wb_ready, 1'b1);
      check($sformatf("starve%0d_rf_rd",   c), bus.rf_rd,         32'd1);
      tick();
    end
    #1;
    check("force_pipe_rdy", bus.pipe_wb_ready, 1'b0);
    check("force_ext_rdy",  bus.ext_ready,     1'b1);
    check("force_rf_rd",    bus.rf_rd,         32'd2);
    check("force_wdata",    bus.rf_wdata,      32'hBBBB0002);
    check("force_wr_en",    bus.rf_wr_en,      1'b1);
    tick();
    check("after_pipe_rdy", bus.pipe_wb_ready, 1'b1);
    check("after_ext_rdy",  bus.ext_ready,     1'b0);
    idle();

    // Writes to x0: handshakes complete, no regfile write, no busy bit.
    bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd0; bus.pipe_wb_data = 32'hFFFFFFFF;
    #1;
    check("x0_pipe_rdy",   bus.pipe_wb_ready, 1'b1);
    check("x0_pipe_wr_en", bus.rf_wr_en,      1'b0);
    tick(); idle();
    bus.ext_valid = 1'b1; bus.ext_rd = 5'd0; bus.ext_data = 32'hCAFEF00D;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    #1;
    check("x0_ext_rdy",   bus.ext_ready,   1'b1);
    check("x0_ext_wr_en", bus.rf_wr_en,    1'b0);
    check("x0_issue_rdy", bus.issue_ready, 1'b1);
    tick(); idle();
    bus.q_rd = 5'd0; bus.issue_rd = 5'd0;
    #1;
    check("x0_not_busy",   bus.rd_busy,     1'b0);
    check("x0_issue_rdy2", bus.issue_ready, 1'b1);

    // Reset asserted during FORCE with x3 busy.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    tick(); idle();
    bus.q_rs1 = 5'd3;
    #1;
    check("x3_busy", bus.rs1_busy, 1'b1);
    bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd1; bus.pipe_wb_data = 32'h1;
    bus.ext_valid     = 1'b1; bus.ext_rd     = 5'd4; bus.ext_data     = 32'h4;
    for (int c = 1; c <= 4; c++) tick();
    #1;
    check("rf_in_force", bus.pipe_wb_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("rf_during_rst", bus.pipe_wb_ready, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    check("rf_post_pipe_rdy", bus.pipe_wb_ready, 1'b1);
    check("rf_post_ext_rdy",  bus.ext_ready,     1'b0);
    check("rf_post_x3_busy",  bus.rs1_busy,      1'b0);
    idle();
    bus.issue_rd = 5'd3;
    #1;
    check("rf_post_x3_issue", bus.issue_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and one long-latency execution unit (mul/div or load miss), and keeps a per-register busy scoreboard for results still outstanding in that unit. Sits between writeback and `regfile`: its write outputs drive `rd`/`write_data`/`wr_en` directly, and its busy outputs feed the hazard/stall unit in decode.

## Interface
- `XLEN`, package, datapath width (32)
- `REG_ADDR_WIDTH`, package, register index width (5)
- `NUM_REGS`, package, architectural registers (32)
- `STARVE_LIMIT`, 4, consecutive blocked cycles of the external unit before it is forced onto the port (≥1)

Ports:
- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `pipe_wb_valid` in 1: pipeline writeback request
- `pipe_wb_rd` in REG_ADDR_WIDTH: pipeline destination
- `pipe_wb_data` in XLEN: pipeline result
- `pipe_wb_ready` out 1: pipeline write accepted this cycle; 0 means writeback must hold
- `ext_valid` in 1: external unit result valid
- `ext_rd` in REG_ADDR_WIDTH: external destination
- `ext_data` in XLEN: external result
- `ext_ready` out 1: external result accepted this cycle
- `issue_valid` in 1: long-latency op dispatched to external unit
- `issue_rd` in REG_ADDR_WIDTH: its destination
- `issue_ready` out 1: dispatch permitted (destination not busy)
- `q_rs1`, `q_rs2`, `q_rd` in REG_ADDR_WIDTH each: hazard query addresses
- `rs1_busy`, `rs2_busy`, `rd_busy` out 1 each: query results
- `rf_rd` out REG_ADDR_WIDTH, `rf_wdata` out XLEN, `rf_wr_en` out 1: regfile write port

## Operation
- FSM states: NORMAL, FORCE. Reset → NORMAL, starve counter 0, all busy bits 0.
- NORMAL: pipeline has priority. `pipe_wb_ready`=1. `ext_ready` = !pipe_wb_valid.
- FORCE: `pipe_wb_ready`=0, `ext_ready`=1; the pipeline request is ignored and must be re-presented.
- Starve counter: +1 every cycle in NORMAL with `ext_valid && !ext_ready`; cleared on any ext acceptance or when `ext_valid`=0. When the counter would reach STARVE_LIMIT, next state = FORCE. FORCE lasts exactly one cycle → NORMAL, counter 0. If `ext_valid` drops while in FORCE, the cycle is wasted (no write), still → NORMAL.
- Write mux: the granted requester drives `rf_rd`/`rf_wdata`; `rf_wr_en` = granted && valid && rd≠0. Writes to x0 are accepted (ready handshake completes) but `rf_wr_en`=0.
- Scoreboard busy[1..NUM_REGS-1]; x0 never busy.
  - Set on `issue_valid && issue_ready` with issue_rd≠0.
  - Cleared on ext acceptance (`ext_valid && ext_ready`) for ext_rd.
  - Set and clear on the same register in the same cycle: set wins.
- `issue_ready` = !busy[issue_rd] (x0 always ready); one outstanding op per destination.
- Query: `*_busy` = busy[q] && !(ext accepted this cycle && ext_rd==q). The regfile's same-cycle forwarding makes the committing value visible, so the bit is masked in the commit cycle.
- Pipeline writes to a busy register are not checked here. The hazard unit must stall using `rd_busy`.

## Timing
- Write path and all ready/busy outputs are combinational from inputs plus state. There is no added latency: data accepted at edge N is written by regfile at edge N.
- Busy set/clear take effect at the edge after the handshake.
- Worst-case ext wait: STARVE_LIMIT+1 cycles from `ext_valid` to acceptance.
- Reset mid-operation: state, counter and scoreboard clear on the reset edge. Outputs during reset follow combinational rules with busy=0 and state NORMAL.

## Structure
- Package: `arb_state_t` enum {NORMAL, FORCE}; reuse XLEN, REG_ADDR_WIDTH, NUM_REGS.
- Sub-module `reg_scoreboard`: busy vector, set/clear ports, three query ports with commit masking.
- Top level holds the FSM, the starve counter and the write mux.

## Test plan
- Pipe-only write x5=0xDEADBEEF with ext idle → `rf_wr_en`=1, `rf_rd`=5, `pipe_wb_ready`=1 same cycle.
- Ext write x7=0x12345678 with pipe idle → `ext_ready`=1, written at that edge; busy[7] (set by earlier issue) reads 0 in the commit cycle.
- Pipe valid every cycle, ext valid, STARVE_LIMIT=4 → ext blocked 4 cycles, cycle 5 FORCE: `pipe_wb_ready`=0, ext written; cycle 6 NORMAL.
- Issue x9, then issue x9 again → second `issue_ready`=0 until ext commits x9. Same-cycle issue x9 plus commit x9 → busy[9]=1 afterwards.
- Ext and pipe writes to x0 → handshakes complete, `rf_wr_en`=0, no busy set.
- Assert reset during FORCE with busy[3]=1 → next cycle state NORMAL, `pipe_wb_ready`=1, `rs1_busy`(q=3)=0.
